pico_mem_initiator: RTL and testbench
=====================================

Name: pico_mem_initiator

Overview:
- Bus-master engine that drives the PicoRV32 native memory interface (mem_valid/mem_ready handshake) as the initiator.
- Lets a non-CPU agent (test sequencer, debug port, DMA front-end) issue single or burst word reads and writes to the SoC RAM and MMIO space, including the counter registers at 0x40000000 and 0x40000004.
- Accepts commands on a valid/ready port and returns one response beat per bus beat on a valid/ready port.

Parameters:
- LEN_W, 4, width of cmd_len; a burst is cmd_len+1 beats (1..16 at default).
- TIMEOUT, 256, cycles mem_valid may stay high without mem_ready before abort; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  engine idle and accepting a command
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  32  start byte address; bits [1:0] ignored
- cmd_wdata  in  32  write data, repeated on every beat (fill semantics)
- cmd_wstrb  in  4  byte strobes for writes; ignored for reads
- cmd_len  in  LEN_W  beats minus one
- rsp_valid  out  1  response beat available
- rsp_ready  in  1  consumer takes the response
- rsp_rdata  out  32  read data; 0 for write beats
- rsp_last  out  1  final beat of the command (normal or aborted)
- rsp_err  out  1  beat aborted by timeout
- busy  out  1  high whenever state != IDLE
- mem_valid  out  1  bus request
- mem_instr  out  1  constant 0
- mem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- mem_wdata  out  32  write data
- mem_wstrb  out  4  cmd_wstrb on writes, 4'b0000 on reads
- mem_ready  in  1  responder completion
- mem_rdata  in  32  responder read data, valid when mem_ready is high

Behaviour:
- Reset (async, resetn low): state = IDLE. mem_valid, rsp_valid, rsp_last, rsp_err and busy = 0. mem_addr, mem_wdata, mem_wstrb and rsp_rdata = 0. cmd_ready = 1 after release. Asserting reset mid-transfer drops mem_valid immediately and discards the remaining beats.
- FSM states:
  - IDLE: cmd_ready = 1. On cmd_valid&&cmd_ready, latch all command fields, set beat counter = cmd_len, go to REQ.
  - REQ: mem_valid = 1. addr, wdata and wstrb are held stable until completion.
    - At the edge where mem_ready = 1: drop mem_valid. Capture mem_rdata (reads) or 0 (writes) into rsp_rdata. rsp_last = (beat counter == 0), rsp_err = 0. Go to RSP.
  - RSP: rsp_valid = 1 and all rsp_* fields are held stable until rsp_ready.
    - At the handshake edge: if last, go to IDLE. Otherwise decrement the beat counter, add 4 to the address and go to REQ.
- Latency:
  - cmd handshake at edge N → mem_valid high after N.
  - mem_ready at edge M → mem_valid low and rsp_valid high after M.
  - rsp handshake at edge K → next mem_valid (or cmd_ready) high after K.
  - Minimum 3 cycles per beat with a 1-cycle responder.
- mem_valid is never reasserted in the cycle after a completion. This guarantees a responder with registered mem_ready sees a clean deassert.
- Address wrap: 0xFFFFFFFC + 4 = 0x00000000, modulo 2^32, no error.
- The timeout counter resets on entry to REQ and counts cycles while mem_ready = 0. On reaching TIMEOUT:
  - drop mem_valid;
  - rsp_valid = 1 with rsp_err = 1, rsp_last = 1, rsp_rdata = 0;
  - the remaining beats are abandoned and the engine returns to IDLE after the rsp handshake.
- mem_ready while in IDLE or RSP is ignored.
- cmd_valid while busy is not accepted; no command queueing.

Optional Feature:
- Macro: PMI_TIMEOUT_EN.
- Defined: timeout counter and abort path are present as described above. TIMEOUT = 0 still disables the timeout.
- Undefined: no timeout counter; REQ waits indefinitely for mem_ready. rsp_err is tied to 0 and TIMEOUT is unused.

Test Plan:
- Single read: cmd read addr=0x40000000 len=0, 1-cycle responder returning 0x0000002A → one rsp beat, rdata=0x0000002A, last=1, err=0; mem_wstrb=0 throughout.
- Single write: cmd write addr=0x40000004 wdata=0x1 wstrb=4'hF → mem_valid one request with addr 0x40000004 and wdata 0x1; rsp rdata=0, last=1; mem_valid low the cycle after mem_ready.
- Burst with backpressure: write fill 0xDEADBEEF addr=0x100 len=3, rsp_ready held low 5 cycles per beat → mem_addr sequence 0x100, 0x104, 0x108, 0x10C; mem_valid never high while rsp_valid is high; last only on beat 4. Follow with a read burst returning all 0xDEADBEEF.
- Wrap and alignment: read addr=0xFFFFFFFE len=1 → mem_addr 0xFFFFFFFC, then 0x00000000.
- Timeout (PMI_TIMEOUT_EN, TIMEOUT=8): responder never asserts ready, len=2 → mem_valid high exactly 8 cycles; one rsp beat with err=1, last=1; then cmd_ready=1.
- Reset mid-burst: resetn low during REQ of beat 2 → mem_valid, rsp_valid and busy go 0 without a clock edge; after release a fresh single read completes normally.

Source files
------------

// File: rtl/pico_mem_initiator.sv
// ============================================================================
//  Module   : pico_mem_initiator
//  Purpose  : Bus-master engine for the PicoRV32 native memory interface.
//             Accepts single/burst word read/write commands on a valid/ready
//             port, drives mem_valid/mem_ready transfers and returns one
//             response beat per bus beat.
//  Options  : PMI_TIMEOUT_EN - when defined, a REQ that waits TIMEOUT cycles
//             without mem_ready is aborted with rsp_err = 1.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pico_mem_initiator #(
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 256
) (
    input  logic             clk,
    input  logic             resetn,
    // command port
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [31:0]      cmd_addr,
    input  logic [31:0]      cmd_wdata,
    input  logic [3:0]       cmd_wstrb,
    input  logic [LEN_W-1:0] cmd_len,
    // response port
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_rdata,
    output logic             rsp_last,
    output logic             rsp_err,
    output logic             busy,
    // PicoRV32 native memory interface
    output logic             mem_valid,
    output logic             mem_instr,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_wstrb,
    input  logic             mem_ready,
    input  logic [31:0]      mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RSP  = 2'd2
    } state_t;

    localparam int                TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TCNT_W-1:0] c_TLIM = TCNT_W'(TIMEOUT - 1);
    localparam bit                c_TO_ON = (TIMEOUT != 0);

    state_t             r_state;
    state_t             w_next;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic [3:0]         r_wstrb;
    logic               r_write;
    logic [LEN_W-1:0]   r_beats;
    logic [31:0]        r_rdata;
    logic               r_last;
    logic               w_timeout;
    logic               w_unused;

    // Byte-offset bits of the command address are dropped on purpose.
    assign w_unused = &{1'b0, cmd_addr[1:0]};

    // Bus and handshake outputs decode straight from the state register so
    // an asynchronous reset removes mem_valid/rsp_valid/busy at once.
    assign cmd_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign mem_valid = (r_state == S_REQ);
    assign rsp_valid = (r_state == S_RSP);
    assign mem_instr = 1'b0;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_wstrb = r_wstrb;
    assign rsp_rdata = r_rdata;
    assign rsp_last  = r_last;

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode. RSP always separates two REQ phases, so mem_valid
    // is never high in the cycle that follows a completion.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (cmd_valid) w_next = S_REQ;
            S_REQ:  if (mem_ready || w_timeout) w_next = S_RSP;
            S_RSP:  if (rsp_ready) w_next = r_last ? S_IDLE : S_REQ;
            default: w_next = S_IDLE;
        endcase
    end

    // Command latch, per-beat address/count stepping and response capture.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
            r_wstrb <= 4'h0;
            r_write <= 1'b0;
            r_beats <= '0;
            r_rdata <= 32'h0;
            r_last  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_addr  <= {cmd_addr[31:2], 2'b00};
                        r_wdata <= cmd_wdata;
                        r_wstrb <= cmd_write ? cmd_wstrb : 4'h0;
                        r_write <= cmd_write;
                        r_beats <= cmd_len;
                        r_last  <= 1'b0;
                    end
                end
                S_REQ: begin
                    if (mem_ready) begin
                        r_rdata <= r_write ? 32'h0 : mem_rdata;
                        r_last  <= (r_beats == '0);
                    end else if (w_timeout) begin
                        // Abort: the remaining beats are abandoned.
                        r_rdata <= 32'h0;
                        r_last  <= 1'b1;
                    end
                end
                S_RSP: begin
                    if (rsp_ready && !r_last) begin
                        r_beats <= r_beats - 1'b1;
                        r_addr  <= r_addr + 32'd4;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef PMI_TIMEOUT_EN
    logic [TCNT_W-1:0] r_tcnt;
    logic              r_err;

    assign w_timeout = c_TO_ON && (r_state == S_REQ) && !mem_ready
                       && (r_tcnt == c_TLIM);
    assign rsp_err   = r_err;

    // Wait-cycle counter; held at zero outside REQ so every REQ starts fresh.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_tcnt <= '0;
        end else if (r_state != S_REQ) begin
            r_tcnt <= '0;
        end else if (!mem_ready) begin
            r_tcnt <= r_tcnt + 1'b1;
        end
    end

    // Error flag: set by an abort, cleared by a normal completion or new command.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_err <= 1'b0;
        end else if (r_state == S_IDLE && cmd_valid) begin
            r_err <= 1'b0;
        end else if (r_state == S_REQ) begin
            if (mem_ready) begin
                r_err <= 1'b0;
            end else if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end
`else
    // No timeout hardware: REQ waits for mem_ready indefinitely.
    logic [TCNT_W:0] w_unused_tlim;
    assign w_unused_tlim = {c_TO_ON, c_TLIM};
    assign w_timeout     = 1'b0;
    assign rsp_err       = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pico_mem_initiator.sv
// ============================================================================
//  Module   : tb_pico_mem_initiator
//  Purpose  : Directed self-checking bench for pico_mem_initiator.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pico_mem_initiator;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic [3:0]  cmd_len;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_last;
    logic        rsp_err;
    logic        busy;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int checks   = 0;
    int failures = 0;

    pico_mem_initiator #(.LEN_W(4), .TIMEOUT(8)) dut (
        .clk(clk), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .cmd_len(cmd_len),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_last(rsp_last), .rsp_err(rsp_err), .busy(busy),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Offer one command for one cycle; returns at the negedge after acceptance.
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [3:0] l);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a;
        cmd_wdata = d; cmd_wstrb = s; cmd_len = l;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Responder + consumer for one beat. ok drops on any protocol violation:
    // no request, unstable request, mem_valid while rsp_valid, response not
    // presented the cycle after mem_ready. Stray mem_ready is driven during RSP.
    task automatic run_beat(input logic [31:0] rd, input int rdy_dly, input int hold,
                            output logic [31:0] a, output logic [31:0] wd,
                            output logic [3:0] ws, output logic [31:0] r,
                            output logic l, output logic e, output logic ok);
        int n;
        ok = 1'b1;
        n  = 0;
        while (mem_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (mem_valid !== 1'b1) ok = 1'b0;
        a = mem_addr; wd = mem_wdata; ws = mem_wstrb;
        for (int i = 0; i < rdy_dly; i++) begin
            @(negedge clk);
            if (mem_valid !== 1'b1 || mem_addr !== a || mem_wdata !== wd || mem_wstrb !== ws)
                ok = 1'b0;
        end
        mem_ready = 1'b1; mem_rdata = rd;
        @(negedge clk);
        mem_ready = 1'b0; mem_rdata = 32'hA5A5_5A5A;
        if (mem_valid !== 1'b0 || rsp_valid !== 1'b1) ok = 1'b0;
        r = rsp_rdata; l = rsp_last; e = rsp_err;
        for (int i = 0; i < hold; i++) begin
            mem_ready = 1'b1;
            @(negedge clk);
            if (mem_valid !== 1'b0 || rsp_valid !== 1'b1 || rsp_rdata !== r || rsp_last !== l)
                ok = 1'b0;
        end
        mem_ready = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        resetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_wstrb = '0; cmd_len = '0; rsp_ready = 1'b0;
        mem_ready = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({mem_valid, rsp_valid, rsp_last, rsp_err, busy, mem_instr} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {mem_valid, rsp_valid, rsp_last, rsp_err, busy, mem_instr});
        end
        checks++;
        if ({mem_addr, mem_wdata, mem_wstrb, rsp_rdata} !== 100'h0) begin
            failures++;
            $display("FAIL reset_data: got %h expected 0",
                     {mem_addr, mem_wdata, mem_wstrb, rsp_rdata});
        end
        resetn = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready);
        end
    endtask

    task automatic test_single_read;
        logic [31:0] a, wd, r; logic [3:0] ws; logic l, e, ok;
        issue(1'b0, 32'h4000_0000, 32'h1234_5678, 4'hF, 4'd0);
        checks++;
        if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL read_busy: got busy=%b cmd_ready=%b expected 1/0", busy, cmd_ready);
        end
        run_beat(32'h0000_002A, 1, 0, a, wd, ws, r, l, e, ok);
        checks++;
        if ({a, ws} !== {32'h4000_0000, 4'h0}) begin
            failures++;
            $display("FAIL read_req: got addr=%h wstrb=%h expected 40000000/0", a, ws);
        end
        checks++;
        if ({r, l, e, ok} !== {32'h0000_002A, 1'b1, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL read_rsp: got rdata=%h last=%b err=%b ok=%b expected 0000002a/1/0/1",
                     r, l, e, ok);
        end
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL read_idle: got cmd_ready=%b busy=%b expected 1/0", cmd_ready, busy);
        end
    endtask

    task automatic test_single_write;
        logic [31:0] a, wd, r; logic [3:0] ws; logic l, e, ok;
        issue(1'b1, 32'h4000_0004, 32'h0000_0001, 4'hF, 4'd0);
        run_beat(32'hFFFF_FFFF, 1, 0, a, wd, ws, r, l, e, ok);
        checks++;
        if ({a, wd, ws} !== {32'h4000_0004, 32'h0000_0001, 4'hF}) begin
            failures++;
            $display("FAIL write_req: got addr=%h wdata=%h wstrb=%h expected 40000004/00000001/f",
                     a, wd, ws);
        end
        checks++;
        if ({r, l, ok} !== {32'h0, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL write_rsp: got rdata=%h last=%b ok=%b expected 0/1/1", r, l, ok);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] a, wd, r; logic [3:0] ws; logic l, e, ok;
        issue(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 4'd3);
        // A competing command held while busy must not be taken.
        cmd_valid = 1'b1; cmd_addr = 32'h0000_0999; cmd_write = 1'b0; cmd_len = 4'd0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) cmd_valid = 1'b0;
            run_beat(32'h1111_0000 + 32'(i), 1, 5, a, wd, ws, r, l, e, ok);
            checks++;
            if ({a, wd, ws, r, l, ok} !== {32'h100 + 32'(4 * i), 32'hDEAD_BEEF, 4'hF,
                                          32'h0, (i == 3), 1'b1}) begin
                failures++;
                $display("FAIL burst_write_beat%0d: got addr=%h wdata=%h wstrb=%h rdata=%h last=%b ok=%b",
                         i, a, wd, ws, r, l, ok);
            end
        end
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL burst_write_end: got cmd_ready=%b busy=%b expected 1/0", cmd_ready, busy);
        end
        issue(1'b0, 32'h0000_0100, 32'h0, 4'hF, 4'd3);
        for (int i = 0; i < 4; i++) begin
            run_beat(32'hDEAD_BEEF, 0, 1, a, wd, ws, r, l, e, ok);
            checks++;
            if ({a, ws, r, l, ok} !== {32'h100 + 32'(4 * i), 4'h0, 32'hDEAD_BEEF,
                                      (i == 3), 1'b1}) begin
                failures++;
                $display("FAIL burst_read_beat%0d: got addr=%h wstrb=%h rdata=%h last=%b ok=%b",
                         i, a, ws, r, l, ok);
            end
        end
    endtask

    task automatic test_wrap;
        logic [31:0] a, wd, r; logic [3:0] ws; logic l, e, ok;
        issue(1'b0, 32'hFFFF_FFFE, 32'h0, 4'h0, 4'd1);
        run_beat(32'h0000_00A1, 1, 0, a, wd, ws, r, l, e, ok);
        checks++;
        if ({a, r, l, ok} !== {32'hFFFF_FFFC, 32'h0000_00A1, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL wrap_beat0: got addr=%h rdata=%h last=%b ok=%b expected fffffffc/a1/0/1",
                     a, r, l, ok);
        end
        run_beat(32'h0000_00A2, 1, 0, a, wd, ws, r, l, e, ok);
        checks++;
        if ({a, r, l, ok} !== {32'h0000_0000, 32'h0000_00A2, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL wrap_beat1: got addr=%h rdata=%h last=%b ok=%b expected 0/a2/1/1",
                     a, r, l, ok);
        end
    endtask

`ifdef PMI_TIMEOUT_EN
    task automatic test_timeout;
        int n;
        issue(1'b0, 32'h0000_0200, 32'h0, 4'h0, 4'd2);
        n = 0;
        while (mem_valid === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != 8) begin
            failures++;
            $display("FAIL timeout_cycles: got %0d expected 8", n);
        end
        checks++;
        if ({rsp_valid, rsp_err, rsp_last, rsp_rdata} !== {3'b111, 32'h0}) begin
            failures++;
            $display("FAIL timeout_rsp: got valid=%b err=%b last=%b rdata=%h expected 1/1/1/0",
                     rsp_valid, rsp_err, rsp_last, rsp_rdata);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || mem_valid !== 1'b0) begin
            failures++;
            $display("FAIL timeout_idle: got cmd_ready=%b busy=%b mem_valid=%b expected 1/0/0",
                     cmd_ready, busy, mem_valid);
        end
    endtask
`else
    task automatic test_no_timeout;
        logic [31:0] a, wd, r; logic [3:0] ws; logic l, e, ok;
        int n;
        issue(1'b0, 32'h0000_0200, 32'h0, 4'h0, 4'd0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (mem_valid === 1'b1 && rsp_valid === 1'b0) n++;
            @(negedge clk);
        end
        checks++;
        if (n != 20) begin
            failures++;
            $display("FAIL no_timeout_wait: got %0d expected 20", n);
        end
        run_beat(32'h0000_0055, 0, 0, a, wd, ws, r, l, e, ok);
        checks++;
        if ({r, l, e, ok} !== {32'h0000_0055, 1'b1, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL no_timeout_rsp: got rdata=%h last=%b err=%b ok=%b expected 55/1/0/1",
                     r, l, e, ok);
        end
    endtask
`endif

    task automatic test_reset_mid;
        logic [31:0] a, wd, r; logic [3:0] ws; logic l, e, ok;
        issue(1'b0, 32'h0000_0300, 32'h0, 4'h0, 4'd3);
        run_beat(32'h0000_0001, 1, 0, a, wd, ws, r, l, e, ok);
        checks++;
        if (mem_valid !== 1'b1 || mem_addr !== 32'h0000_0304) begin
            failures++;
            $display("FAIL mid_beat2_req: got mem_valid=%b addr=%h expected 1/00000304",
                     mem_valid, mem_addr);
        end
        #2 resetn = 1'b0;
        #1;
        checks++;
        if ({mem_valid, rsp_valid, busy} !== 3'b000) begin
            failures++;
            $display("FAIL mid_async_reset: got valid/rsp/busy=%b expected 000",
                     {mem_valid, rsp_valid, busy});
        end
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || mem_addr !== 32'h0) begin
            failures++;
            $display("FAIL mid_after_release: got cmd_ready=%b addr=%h expected 1/0",
                     cmd_ready, mem_addr);
        end
        issue(1'b0, 32'h4000_0000, 32'h0, 4'h0, 4'd0);
        run_beat(32'h0000_0077, 1, 0, a, wd, ws, r, l, e, ok);
        checks++;
        if ({a, r, l, e, ok} !== {32'h4000_0000, 32'h0000_0077, 1'b1, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL mid_fresh_read: got addr=%h rdata=%h last=%b err=%b ok=%b",
                     a, r, l, e, ok);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_single_write();
        test_back_to_back();
        test_wrap();
`ifdef PMI_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
